// File: rtl/sd_iir_filter_mc.sv
// Time-multiplexed sigma-delta IIR filter: one shared STAGES-deep datapath evaluates one
// channel per clock, with double-buffered coefficients committed on frame boundaries.
module sd_iir_filter_mc #(
    parameter int               WIDTH    = 32,
    parameter int               STAGES   = 4,
    parameter int               CHANNELS = 2,
    parameter int               SHIFT    = 7,
    parameter int               SAT      = 0,
    parameter logic [WIDTH-1:0] SD_INIT  = '0,
    localparam int              NCOEF    = 2 * STAGES + 1,
    localparam int              AW       = $clog2(NCOEF)
) (
    input  logic                filter_clock,
    input  logic                reset,
    input  logic                sample_strobe,
    input  logic [CHANNELS-1:0] bit_in,
    output logic [CHANNELS-1:0] bit_out,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun,
    input  logic                coef_we,
    input  logic [AW-1:0]       coef_addr,
    input  logic [WIDTH-1:0]    coef_wdata,
    input  logic                coef_commit
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic signed [WIDTH-1:0] word_t;

    // Every node is computed one bit wider, then either wrapped or clamped back to WIDTH.
    function automatic word_t clamp(input logic signed [WIDTH:0] v);
        if (SAT != 0 && v[WIDTH] != v[WIDTH-1])
            return v[WIDTH] ? MIN_V : MAX_V;
        return v[WIDTH-1:0];
    endfunction

    function automatic word_t s_add(input word_t a, input word_t b);
        return clamp({a[WIDTH-1], a} + {b[WIDTH-1], b});
    endfunction

    function automatic word_t s_sub(input word_t a, input word_t b);
        return clamp({a[WIDTH-1], a} - {b[WIDTH-1], b});
    endfunction

    function automatic word_t pm(input word_t g, input logic sel);
        return sel ? g : s_sub('0, g);
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [CHANNELS-1:0]   bits_q, bits_d;
    logic [CHANNELS-1:0]   bit_out_q, bit_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  pend_q, pend_d;
    logic                  apply_commit;

    word_t d_q      [CHANNELS][STAGES];
    word_t d_d      [CHANNELS][STAGES];
    word_t sd_q     [CHANNELS];
    word_t sd_d     [CHANNELS];
    word_t shadow_q [NCOEF];
    word_t shadow_d [NCOEF];
    word_t active_q [NCOEF];
    word_t active_d [NCOEF];

    word_t d_cur [STAGES];
    word_t d_new [STAGES];
    logic  x_cur, q_cur;
    word_t s_val, fs_val, sd_new;

    assign x_cur = bits_q[ch_q];
    assign q_cur = ~sd_q[ch_q][WIDTH-1];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        word_t fwd, acc;
        assign d_cur[gi] = d_q[ch_q][gi];
        if (gi == 0) begin : g_first
            assign fwd = '0;
        end else begin : g_rest
            assign fwd = d_cur[gi-1] >>> SHIFT;
        end
        assign acc       = s_add(s_sub(pm(active_q[gi], x_cur),
                                       pm(active_q[STAGES+1+gi], q_cur)), fwd);
        assign d_new[gi] = s_sub(acc, d_cur[gi]);
    end

    assign s_val  = s_add(pm(active_q[STAGES], x_cur), d_cur[STAGES-1] >>> SHIFT);
    assign fs_val = q_cur ? MAX_V : MIN_V;
    assign sd_new = s_sub(s_sub(s_val, fs_val), sd_q[ch_q]);

    always_comb begin
        d_d  = d_q;
        sd_d = sd_q;
        if (state_q == RUN) begin
            for (int k = 0; k < STAGES; k++)
                d_d[ch_q][k] = d_new[k];
            sd_d[ch_q] = sd_new;
        end
    end

    // Shadow write is folded in before the copy so a same-cycle write joins the commit.
    always_comb begin
        shadow_d     = shadow_q;
        active_d     = active_q;
        pend_d       = pend_q;
        apply_commit = 1'b0;
        if (coef_we && coef_addr < AW'(NCOEF))
            shadow_d[coef_addr] = coef_wdata;
        case (state_q)
            IDLE:    apply_commit = coef_commit;
            RUN:     pend_d = pend_q | coef_commit;
            default: begin
                apply_commit = pend_q | coef_commit;
                pend_d       = 1'b0;
            end
        endcase
        if (apply_commit)
            active_d = shadow_d;
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        bits_d      = bits_q;
        bit_out_d   = bit_out_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    bits_d  = bit_in;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sample_strobe)
                    overrun_d = 1'b1;
                if (ch_q == CW'(CHANNELS - 1))
                    state_d = DONE;
                else
                    ch_d = ch_q + 1'b1;
            end
            default: begin
                if (sample_strobe)
                    overrun_d = 1'b1;
                for (int c = 0; c < CHANNELS; c++)
                    bit_out_d[c] = ~sd_q[c][WIDTH-1];
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge filter_clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            bits_q      <= '0;
            bit_out_q   <= {CHANNELS{~SD_INIT[WIDTH-1]}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            pend_q      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                sd_q[c] <= SD_INIT;
                for (int k = 0; k < STAGES; k++)
                    d_q[c][k] <= '0;
            end
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            bits_q      <= bits_d;
            bit_out_q   <= bit_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            pend_q      <= pend_d;
            d_q         <= d_d;
            sd_q        <= sd_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_sd_iir_filter_mc.sv
// Bench for sd_iir_filter_mc: wrapping and saturating instances run in lockstep against
// an integer-arithmetic model of the filter equations.
module tb_sd_iir_filter_mc;
    logic        filter_clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_strobe = 1'b0;
    logic [1:0]  bit_in = 2'b00;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = 4'd0;
    logic [31:0] coef_wdata = 32'd0;
    logic        coef_commit = 1'b0;
    logic [1:0]  bit_out, bit_out_s;
    logic        out_valid, out_valid_s, busy, busy_s, overrun, overrun_s;

    int tests = 0;
    int failed = 0;
    int frame_no = 0;

    longint md  [2][2][4];
    longint msd [2][2];
    longint mact [9];
    longint msh  [9];
    logic [1:0] mexp [2];

    always #5 filter_clock = ~filter_clock;

    sd_iir_filter_mc #(.WIDTH(32), .STAGES(4), .CHANNELS(2), .SHIFT(7), .SAT(0), .SD_INIT(32'h0)) dut (
        .filter_clock(filter_clock), .reset(reset), .sample_strobe(sample_strobe), .bit_in(bit_in),
        .bit_out(bit_out), .out_valid(out_valid), .busy(busy), .overrun(overrun),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit));

    sd_iir_filter_mc #(.WIDTH(32), .STAGES(4), .CHANNELS(2), .SHIFT(7), .SAT(1), .SD_INIT(32'h0)) dut_s (
        .filter_clock(filter_clock), .reset(reset), .sample_strobe(sample_strobe), .bit_in(bit_in),
        .bit_out(bit_out_s), .out_valid(out_valid_s), .busy(busy_s), .overrun(overrun_s),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit));

    function automatic longint nrm(input longint v, input int sat);
        longint lo;
        longint hi;
        logic [31:0] w;
        lo = -(longint'(1) << 31);
        hi = (longint'(1) << 31) - 1;
        if (sat != 0)
            return (v < lo) ? lo : ((v > hi) ? hi : v);
        w = v[31:0];
        return longint'($signed(w));
    endfunction

    function automatic longint pmv(input longint g, input bit sel, input int sat);
        return sel ? g : nrm(-g, sat);
    endfunction

    task automatic model_reset;
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++) begin
                msd[s][c] = 0;
                for (int k = 0; k < 4; k++) md[s][c][k] = 0;
            end
        for (int i = 0; i < 9; i++) begin
            mact[i] = 0;
            msh[i] = 0;
        end
    endtask

    task automatic model_frame(input logic [1:0] bits);
        longint od [4];
        longint acc, sv, fs, nsd;
        bit x, q;
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++) begin
                x = bits[c];
                q = (msd[s][c] >= 0);
                for (int k = 0; k < 4; k++) od[k] = md[s][c][k];
                for (int k = 0; k < 4; k++) begin
                    acc = nrm(pmv(mact[k], x, s) - pmv(mact[5+k], q, s), s);
                    acc = nrm(acc + ((k > 0) ? (od[k-1] >>> 7) : 0), s);
                    md[s][c][k] = nrm(acc - od[k], s);
                end
                sv = nrm(pmv(mact[4], x, s) + (od[3] >>> 7), s);
                fs = q ? ((longint'(1) << 31) - 1) : -(longint'(1) << 31);
                nsd = nrm(nrm(sv - fs, s) - msd[s][c], s);
                msd[s][c] = nsd;
                mexp[s][c] = (nsd >= 0);
            end
    endtask

    task automatic tick;
        @(posedge filter_clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        sample_strobe = 1'b0;
        coef_we = 1'b0;
        coef_commit = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        model_reset;
    endtask

    task automatic write_coef(input int addr, input logic [31:0] data, input bit with_commit);
        coef_we = 1'b1;
        coef_addr = 4'(addr);
        coef_wdata = data;
        coef_commit = with_commit;
        tick;
        coef_we = 1'b0;
        coef_commit = 1'b0;
        msh[addr] = longint'($signed(data));
        if (with_commit) mact = msh;
    endtask

    task automatic commit_idle;
        coef_commit = 1'b1;
        tick;
        coef_commit = 1'b0;
        mact = msh;
    endtask

    task automatic run_frame(input logic [1:0] bits);
        int n;
        bit_in = bits;
        sample_strobe = 1'b1;
        tick;
        sample_strobe = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        model_frame(bits);
        frame_no++;
        $display("[TB] frame %0d bits=%b out=%b sat_out=%b expect=%b/%b",
                 frame_no, bits, bit_out, bit_out_s, mexp[0], mexp[1]);
        tests++;
        if (n !== 3) begin
            failed++;
            $display("FAIL latency: got %0d cycles after strobe edge, want 3", n);
        end
        tests++;
        if (bit_out !== mexp[0]) begin
            failed++;
            $display("FAIL bit_out_wrap: got %b want %b", bit_out, mexp[0]);
        end
        tests++;
        if (bit_out_s !== mexp[1]) begin
            failed++;
            $display("FAIL bit_out_sat: got %b want %b", bit_out_s, mexp[1]);
        end
    endtask

    task automatic test_reset;
        do_reset;
        repeat (10) tick;
        tests++;
        if (bit_out !== 2'b11 || bit_out_s !== 2'b11 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: got bit_out=%b/%b ov=%b busy=%b overrun=%b want 11/11 0 0 0",
                     bit_out, bit_out_s, out_valid, busy, overrun);
        end
    endtask

    task automatic test_basic;
        write_coef(4, 32'h1000_0000, 1'b0);
        commit_idle;
        bit_in = 2'b01;
        sample_strobe = 1'b1;
        tick;
        sample_strobe = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tests++;
            if (busy !== 1'b1 || busy_s !== 1'b1 || out_valid !== 1'b0) begin
                failed++;
                $display("FAIL busy_window t+%0d: got busy=%b ov=%b want busy=1 ov=0", i, busy, out_valid);
            end
            tick;
        end
        model_frame(2'b01);
        tests++;
        if (out_valid !== 1'b1 || out_valid_s !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL out_valid_t4: got ov=%b busy=%b want ov=1 busy=0", out_valid, busy);
        end
        tests++;
        if (bit_out[0] !== 1'b0 || bit_out !== mexp[0] || bit_out_s !== mexp[1]) begin
            failed++;
            $display("FAIL basic_bit_out: got %b/%b want %b/%b", bit_out, bit_out_s, mexp[0], mexp[1]);
        end
        tests++;
        if (dut.sd_q[0] !== 32'h9000_0001) begin
            failed++;
            $display("FAIL basic_sd0: got %h want 90000001", dut.sd_q[0]);
        end
        tick;
        tests++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL out_valid_pulse: got %b want 0", out_valid);
        end
    endtask

    task automatic test_random;
        logic [31:0] v;
        for (int f = 0; f < 256; f++) begin
            if (f % 32 == 0) begin
                for (int a = 0; a < 9; a++) begin
                    v = $urandom;
                    v = $unsigned($signed(v) >>> $urandom_range(0, 24));
                    write_coef(a, v, a == 8);
                end
            end
            run_frame(2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick;
        end
        tests++;
        if (overrun !== 1'b0 || overrun_s !== 1'b0) begin
            failed++;
            $display("FAIL min_spacing_overrun: got %b want 0", overrun);
        end
    endtask

    task automatic test_overrun;
        int pulses;
        logic [1:0] bits, cap;
        bits = 2'($urandom_range(0, 3));
        cap = 2'bxx;
        bit_in = bits;
        sample_strobe = 1'b1;
        tick;
        bit_in = ~bits;
        tick;
        sample_strobe = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) begin
                pulses++;
                cap = bit_out;
            end
            tick;
        end
        model_frame(bits);
        tests++;
        if (pulses !== 1) begin
            failed++;
            $display("FAIL overrun_pulses: got %0d want 1", pulses);
        end
        tests++;
        if (cap !== mexp[0]) begin
            failed++;
            $display("FAIL overrun_frame_data: got %b want %b", cap, mexp[0]);
        end
        repeat (5) tick;
        tests++;
        if (overrun !== 1'b1 || overrun_s !== 1'b1) begin
            failed++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
        do_reset;
        tests++;
        if (overrun !== 1'b0) begin
            failed++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
    endtask

    task automatic test_commit_pending;
        int n;
        logic [31:0] exp0;
        do_reset;
        bit_in = 2'b11;
        sample_strobe = 1'b1;
        tick;
        sample_strobe = 1'b0;
        coef_we = 1'b1;
        coef_addr = 4'd0;
        coef_wdata = 32'h0000_4000;
        coef_commit = 1'b1;
        tick;
        coef_we = 1'b0;
        coef_commit = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            tick;
            n++;
        end
        model_frame(2'b11);
        msh[0] = 64'h4000;
        mact = msh;
        exp0 = md[0][0][0][31:0];
        tests++;
        if (n !== 2 || dut.d_q[0][0] !== exp0) begin
            failed++;
            $display("FAIL commit_old_frame: got d0=%h lat=%0d want d0=%h lat=2", dut.d_q[0][0], n, exp0);
        end
        run_frame(2'b11);
        exp0 = md[0][0][0][31:0];
        tests++;
        if (dut.d_q[0][0] !== 32'h0000_4000 || dut.d_q[0][0] !== exp0) begin
            failed++;
            $display("FAIL commit_next_frame: got d0=%h want %h", dut.d_q[0][0], exp0);
        end
    endtask

    task automatic test_saturation;
        do_reset;
        write_coef(0, 32'h7FFF_FFFF, 1'b0);
        write_coef(5, 32'h8000_0001, 1'b0);
        commit_idle;
        run_frame(2'b11);
        tests++;
        if (dut.d_q[0][0] !== 32'hFFFF_FFFE) begin
            failed++;
            $display("FAIL wrap_d0: got %h want fffffffe", dut.d_q[0][0]);
        end
        tests++;
        if (dut_s.d_q[0][0] !== 32'h7FFF_FFFF) begin
            failed++;
            $display("FAIL sat_d0: got %h want 7fffffff", dut_s.d_q[0][0]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int pulses;
        do_reset;
        write_coef(4, 32'h1000_0000, 1'b0);
        commit_idle;
        bit_in = 2'b01;
        sample_strobe = 1'b1;
        tick;
        sample_strobe = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_reset;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0 || out_valid_s !== 1'b0) pulses++;
            tick;
        end
        tests++;
        if (pulses !== 0 || busy !== 1'b0 || bit_out !== 2'b11) begin
            failed++;
            $display("FAIL abort_outputs: got pulses=%0d busy=%b bit_out=%b want 0 0 11", pulses, busy, bit_out);
        end
        tests++;
        if (dut.sd_q[0] !== 32'h0 || dut.sd_q[1] !== 32'h0) begin
            failed++;
            $display("FAIL abort_state: got sd=%h/%h want 0/0", dut.sd_q[0], dut.sd_q[1]);
        end
        write_coef(4, 32'h1000_0000, 1'b0);
        commit_idle;
        run_frame(2'b01);
        tests++;
        if (bit_out[0] !== 1'b0 || dut.sd_q[0] !== 32'h9000_0001) begin
            failed++;
            $display("FAIL after_abort: got bit0=%b sd0=%h want 0 90000001", bit_out[0], dut.sd_q[0]);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_random;
        test_overrun;
        test_commit_pending;
        test_saturation;
        test_reset_mid_frame;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
